// File: rtl/ps2_keypad.sv
// PS/2 keyboard receiver: input conditioning, 11-bit frame deframer and
// scan-code set 2 decoder producing one-cycle game command pulses.
module ps2_keypad #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       retract,
  output logic       retry
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronisers idle high so reset never fabricates a falling edge.
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic          ext_q, brk_q;

  logic [7:0]    scan_code_q;
  logic          scan_valid_q, frame_err_q;
  logic          up_q, down_q, left_q, right_q, retract_q, retry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall_d = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall_d = ~clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      fall_q <= fall_d;
    end
  end

  // Deframer, timeout watchdog and decoder share one registered FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      retract_q    <= 1'b0;
      retry_q      <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      retract_q    <= 1'b0;
      retry_q      <= 1'b0;

      if (fall_q) begin
        to_cnt_q <= '0;
      end else if (state_q != IDLE) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      if (state_q != IDLE && !fall_q && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
        to_cnt_q    <= '0;
      end else if (fall_q) begin
        case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (dat_s2_q && (^{shift_q, par_q})) begin
              scan_code_q  <= shift_q;
              scan_valid_q <= 1'b1;
              if (shift_q == 8'hE0) begin
                ext_q <= 1'b1;
              end else if (shift_q == 8'hF0) begin
                brk_q <= 1'b1;
              end else begin
                if (!brk_q) begin
                  if (ext_q) begin
                    case (shift_q)
                      8'h75:   up_q    <= 1'b1;
                      8'h72:   down_q  <= 1'b1;
                      8'h6B:   left_q  <= 1'b1;
                      8'h74:   right_q <= 1'b1;
                      default: ;
                    endcase
                  end else begin
                    case (shift_q)
                      8'h66:   retract_q <= 1'b1;
                      8'h2D:   retry_q   <= 1'b1;
                      default: ;
                    endcase
                  end
                end
                ext_q <= 1'b0;
                brk_q <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;
  assign up         = up_q;
  assign down       = down_q;
  assign left       = left_q;
  assign right      = right_q;
  assign retract    = retract_q;
  assign retry      = retry_q;

endmodule

// File: doc/ps2_keypad.md
# ps2_keypad

PS/2 keyboard receiver and key decoder that sits directly upstream of the game core. It synchronises and de-glitches the raw `ps2_clk`/`ps2_data` lines and deserialises 11-bit device-to-host frames. It then decodes scan-code set 2 (including E0/F0 prefixes) into single-cycle command pulses: four arrow moves, retract and retry. All logic runs on the system clock.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronised samples required before the filtered `ps2_clk` changes.
- `TIMEOUT_CYCLES`, default 5000: system clocks allowed between falling edges inside a frame before it is aborted.
- `clk`  in  1  system clock (`sys_clk` at top level).
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous.
- `scan_code`  out  8  last accepted data byte.
- `scan_valid`  out  1  one-cycle pulse when `scan_code` updates.
- `frame_err`  out  1  one-cycle pulse on parity, stop-bit or timeout error.
- `up`, `down`, `left`, `right`  out  1 each  one-cycle move pulses.
- `retract`  out  1  one-cycle undo pulse.
- `retry`  out  1  one-cycle restart pulse.

## Operation
- **Input conditioning.** Each line passes through a 2-flop synchroniser.
  - `ps2_clk` then passes through a saturating counter filter: the filtered value changes only after `FILTER_LEN` consecutive cycles of the new level.
  - The filtered clock resets to 1.
  - A falling edge of the filtered clock produces a one-cycle `fall` strobe.
  - Data is sampled from the synchronised `ps2_data` in the `fall` cycle.
- **Deframer FSM** states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, a sampled 0 (start bit) moves to DATA with the bit count cleared. A sampled 1 stays in IDLE with no error.
  - DATA: shift right, LSB first. After the 8th bit, move to PARITY.
  - PARITY: store the sampled bit, move to STOP.
  - STOP: check that the stop bit is 1 and that data plus parity have odd total parity.
    - Pass: byte accepted.
    - Fail: `frame_err` pulse, byte discarded, E0/F0 flags cleared.
    - Either way, go to IDLE.
  - Timeout: a counter clears on every `fall` and counts while not in IDLE. On reaching `TIMEOUT_CYCLES`, the FSM goes to IDLE and pulses `frame_err`; E0/F0 flags are cleared.
- **Decoder**, acting on each accepted byte:
  - `scan_valid` always pulses and `scan_code` takes the byte (prefixes included).
  - `0xE0` sets `ext`; `0xF0` sets `brk`. No command is issued for either.
  - Any other byte: if `brk` = 0, it is a make code and is mapped below. Both flags then clear.
    - With `ext` = 1: `0x75`→`up`, `0x72`→`down`, `0x6B`→`left`, `0x74`→`right`.
    - With `ext` = 0: `0x66` (Backspace)→`retract`, `0x2D` (R)→`retry`.
    - All other codes: no command.
  - Break codes (`brk` = 1) issue no command.
  - Typematic repeats are make codes, so each repeat issues a pulse.
- **Exclusivity.** At most one command output is high in any cycle.
- **Reset values.** All outputs, flags, counters and `scan_code` reset to 0. The FSM resets to IDLE and the filter state to 1.

## Timing
- The `fall` strobe occurs `2 + FILTER_LEN` cycles after the raw falling edge (±1).
- For an accepted stop bit, `scan_valid` and any command pulse assert in the cycle after the STOP-state `fall`. They stay high for exactly one cycle.
- `frame_err` follows the same one-cycle-after rule, or asserts the cycle after the timeout count is reached.
- Reset asserted mid-frame discards the partial frame. No pulse is issued during or after reset.
- Reset and `fall` in the same cycle: reset wins.
- A glitch on `ps2_clk` shorter than `FILTER_LEN` cycles produces no `fall` and no shifted bit.
- Back-to-back frames need no idle gap. The first `fall` after STOP is treated as a start bit.

## Test plan
- **Left arrow.** Frames `0xE0` then `0x6B`, 12.5 kHz PS/2 clock, `clk` 50 MHz → two `scan_valid` pulses (`E0`, `6B`) and exactly one `left` pulse, one cycle wide, with the second `scan_valid`. No other command fires.
- **Break suppression.** `E0 F0 75` → three `scan_valid` pulses, no `up` pulse. Flags are clear afterwards, so a following `E0 75` gives one `up`.
- **Retry and retract.** `0x2D` → `retry`. `0x66` → `retract`. `0x6B` without E0 → no `left`.
- **Parity error.** `0x2D` with even parity → `frame_err` pulse, no `scan_valid`, no `retry`. A following `0x2D` with correct parity → `retry`.
- **Timeout and glitch.**
  - Stop toggling after 4 data bits → `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last `fall` (±1), FSM back in IDLE, next frame decoded correctly.
  - A 3-cycle low glitch on idle `ps2_clk` → no state change.
- **Reset mid-frame.** Assert `reset` for one cycle after bit 5 of `E0` → no outputs. A subsequent complete `E0 74` yields one `right` pulse.
